regfile_mp: RTL

- Parametrised multi-read-port register file with a dedicated program-counter register, for the next-generation CPU datapath.
- Provides NUM_RD registered read ports, one write port, and a PC register that loads or auto-increments.
- A post-reset clear sweep zeroes all general registers, so software never sees X values.
- Sits between decode (read selects), writeback (write port) and fetch (PC).

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_clear_seq.sv | 48 ++++
 rtl/regfile_mp.sv | 115 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and defaults for regfile_mp.
//   fsm_state_t  : clear-sweep sequencer states
//   PC_RESET_DEF : default PC reset value
//   PC_STEP_DEF  : default PC increment
//   pc_idx()     : register index that aliases the PC
package regfile_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } fsm_state_t;

  localparam logic [15:0] PC_RESET_DEF = 16'h0100;
  localparam int unsigned PC_STEP_DEF  = 1;

  function automatic int unsigned pc_idx(input int unsigned num_regs);
    return num_regs - 1;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: post-reset sweep that zeroes the general registers.
//   clk, reset : clock, async active-high reset
//   clr_we     : storage clear strobe (high while sweeping)
//   clr_addr   : storage index being cleared
//   ready      : high once every general register has been cleared
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter  int unsigned NUM_REGS = 16,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          ready
);

  localparam logic [AW-1:0] LAST_IDX = AW'(pc_idx(NUM_REGS) - 1);

  fsm_state_t    state;
  logic [AW-1:0] clear_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CLEAR;
      clear_idx <= '0;
      ready     <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clear_idx <= clear_idx + AW'(1);
          if (clear_idx == LAST_IDX) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign clr_we   = (state == CLEAR);
  assign clr_addr = clear_idx;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with a built-in PC register.
//   clk, reset        : clock, async active-high reset
//   rd_en/rd_sel      : capture NUM_RD registered read ports (packed selects)
//   rd_data           : packed registered read data, one-cycle latency
//   wr_en/wr_addr/... : single write port; index NUM_REGS-1 targets the PC
//   pc_inc, pc        : PC auto-increment and current PC
//   dbg_sel, dbg_data : combinational register view
//   ready             : high once the post-reset clear sweep is done
// Optional: `define REGFILE_BYPASS_EN for write-first reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned       DATA_W   = 16,
  parameter  int unsigned       NUM_REGS = 16,
  parameter  int unsigned       NUM_RD   = 2,
  parameter  logic [DATA_W-1:0] PC_RESET = DATA_W'(PC_RESET_DEF),
  parameter  int unsigned       PC_STEP  = PC_STEP_DEF,
  localparam int unsigned       AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_en,
  input  logic [NUM_RD*AW-1:0]     rd_sel,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pc_inc,
  output logic [DATA_W-1:0]        pc,
  input  logic [AW-1:0]            dbg_sel,
  output logic [DATA_W-1:0]        dbg_data,
  output logic                     ready
);

  localparam logic [AW-1:0] PC_IDX = AW'(pc_idx(NUM_REGS));

  logic              clr_we;
  logic [AW-1:0]     clr_addr;
  logic [DATA_W-1:0] regs [NUM_REGS-1];
  logic [DATA_W-1:0] view [NUM_REGS];
  logic [DATA_W-1:0] pc_plus;
  logic              pc_wr;
  logic [DATA_W-1:0] rd_q [NUM_RD];

  regfile_clear_seq #(
    .NUM_REGS(NUM_REGS)
  ) u_clear_seq (
    .clk     (clk),
    .reset   (reset),
    .clr_we  (clr_we),
    .clr_addr(clr_addr),
    .ready   (ready)
  );

  assign pc_plus = pc + DATA_W'(PC_STEP);
  assign pc_wr   = wr_en && (wr_addr == PC_IDX);

  // clr_we is high exactly while not ready, so it also masks the write port.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs[clr_addr] <= '0;
    end else if (wr_en && !pc_wr) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= PC_RESET;
    end else if (ready) begin
      if (pc_wr) begin
        pc <= wr_data;
      end else if (pc_inc) begin
        pc <= pc_plus;
      end
    end
  end

  // Unified index space: general registers plus the PC at the top index.
  for (genvar g = 0; g < NUM_REGS - 1; g++) begin : g_view
    assign view[g] = regs[g];
  end
  assign view[NUM_REGS-1] = pc;

  assign dbg_data = view[dbg_sel];

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0]     sel;
    logic [DATA_W-1:0] nxt;

    assign sel = rd_sel[g*AW +: AW];

    always_comb begin
      nxt = view[sel];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wr_addr == sel)) begin
        nxt = wr_data;
      end else if (pc_inc && (sel == PC_IDX)) begin
        nxt = pc_plus;
      end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_q[g] <= '0;
      end else if (ready && rd_en) begin
        rd_q[g] <= nxt;
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = rd_q[g];
  end

endmodule
